// File: rtl/pic32_popcount_collector_pkg.sv
// Shared definitions for the popcount collector and its MCU-side model.
// Holds the FSM state encoding and the default accumulator geometry.
package pic32_popcount_collector_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_SEND  = 1'b1
  } state_t;

  localparam int ACC_WIDTH_DEF = 16;
  localparam int NIBBLES       = ACC_WIDTH_DEF / 4;

endpackage

// File: rtl/pic32_port_sync_edge.sv
// Synchronises one asynchronous MCU pin into the board clock domain.
// Emits a single-cycle pulse on each rising edge of the synchronised level.
module pic32_port_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pic32_popcount_collector.sv
// Sums per-byte popcounts into a saturating burst total, then hands the total
// back to the MCU one nibble per ack, least significant nibble first.
module pic32_popcount_collector
  import pic32_popcount_collector_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3:0]           count_in,
  input  logic                 mcu_strobe,
  input  logic                 mcu_done,
  input  logic                 mcu_ack,
  output logic [3:0]           port_d,
  output logic                 result_valid,
  output logic                 overrun,
  output logic [CNT_WIDTH-1:0] leds
);

  localparam int NIB   = ACC_WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t               state;
  state_t               state_next;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] sr;
  logic [ACC_WIDTH-1:0] sr_shifted;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] acc_add;
  logic [ACC_WIDTH-1:0] snap_value;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [IDX_W-1:0]     nib_idx;
  logic                 last_nib;

  logic strobe_pulse;
  logic done_pulse;
  logic ack_pulse;

  logic do_add;
  logic do_snap;
  logic do_shift;
  logic do_finish;
  logic set_overrun;

  pic32_port_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_strobe (
    .clock    (clock),
    .reset    (reset),
    .async_in (mcu_strobe),
    .rise     (strobe_pulse)
  );

  pic32_port_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_done (
    .clock    (clock),
    .reset    (reset),
    .async_in (mcu_done),
    .rise     (done_pulse)
  );

  pic32_port_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ack (
    .clock    (clock),
    .reset    (reset),
    .async_in (mcu_ack),
    .rise     (ack_pulse)
  );

  // Carry out of the widened sum means the total no longer fits: pin to all-ones.
  assign sum        = {1'b0, acc} + {{(ACC_WIDTH-3){1'b0}}, count_in};
  assign acc_add    = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
  assign cnt_inc    = (cnt == '1) ? cnt : cnt + CNT_WIDTH'(1);
  assign snap_value = do_add ? acc_add : acc;
  assign sr_shifted = sr >> 4;
  assign last_nib   = (nib_idx == IDX_W'(NIB - 1));
  assign leds       = cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    do_add      = 1'b0;
    do_snap     = 1'b0;
    do_shift    = 1'b0;
    do_finish   = 1'b0;
    set_overrun = 1'b0;
    case (state)
      ST_ACCUM: begin
        do_add = strobe_pulse;
        if (done_pulse) begin
          do_snap    = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        set_overrun = strobe_pulse;
        if (ack_pulse) begin
          if (last_nib) begin
            do_finish  = 1'b1;
            state_next = ST_ACCUM;
          end else begin
            do_shift = 1'b1;
          end
        end
      end
      default: state_next = ST_ACCUM;
    endcase
  end

  // A same-cycle strobe is folded into the snapshot so no sample is lost at burst end.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc          <= '0;
      sr           <= '0;
      cnt          <= '0;
      nib_idx      <= '0;
      port_d       <= 4'h0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (do_add) begin
        acc <= acc_add;
        cnt <= cnt_inc;
      end
      if (do_snap) begin
        sr           <= snap_value;
        nib_idx      <= '0;
        port_d       <= snap_value[3:0];
        result_valid <= 1'b1;
      end
      if (do_shift) begin
        sr      <= sr_shifted;
        nib_idx <= nib_idx + IDX_W'(1);
        port_d  <= sr_shifted[3:0];
      end
      if (do_finish) begin
        acc          <= '0;
        sr           <= '0;
        cnt          <= '0;
        nib_idx      <= '0;
        port_d       <= 4'h0;
        result_valid <= 1'b0;
      end
      if (set_overrun) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pic32_popcount_collector.sv
// Self-checking bench: an MCU-side model predicts each burst total and queues
// its nibbles, which are compared as the collector returns them.
module tb_pic32_popcount_collector;
  import pic32_popcount_collector_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] count_in;
  logic       mcu_strobe;
  logic       mcu_done;
  logic       mcu_ack;
  logic [3:0] port_d;
  logic       result_valid;
  logic       overrun;
  logic [7:0] leds;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  int         model_acc;
  int         model_cnt;
  bit         in_send;
  logic [3:0] e;

  pic32_popcount_collector dut (
    .clock        (clock),
    .reset        (reset),
    .count_in     (count_in),
    .mcu_strobe   (mcu_strobe),
    .mcu_done     (mcu_done),
    .mcu_ack      (mcu_ack),
    .port_d       (port_d),
    .result_valid (result_valid),
    .overrun      (overrun),
    .leds         (leds)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pushResult();
    for (int i = 0; i < NIBBLES; i++)
      exp_q.push_back(4'((model_acc >> (4 * i)) & 15));
    in_send = 1'b1;
  endtask

  // Strobe (optionally together with done); the model only adds while accumulating.
  task automatic applyStimulus(input logic [3:0] c, input bit with_done);
    count_in   = c;
    mcu_strobe = 1'b1;
    if (with_done) mcu_done = 1'b1;
    tick(2);
    mcu_strobe = 1'b0;
    mcu_done   = 1'b0;
    tick(2);
    if (!in_send) begin
      model_acc = (model_acc + int'(c) > 65535) ? 65535 : model_acc + int'(c);
      model_cnt = (model_cnt == 255) ? 255 : model_cnt + 1;
      if (with_done) pushResult();
    end
  endtask

  task automatic sendDone();
    mcu_done = 1'b1;
    tick(2);
    mcu_done = 1'b0;
    tick(2);
    if (!in_send) pushResult();
  endtask

  task automatic sendAck(input int hold);
    mcu_ack = 1'b1;
    tick(hold);
    mcu_ack = 1'b0;
    tick(3);
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (!result_valid && n < 20) begin
      tick(1);
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(result_valid), 32'd1);
  endtask

  task automatic readout(input string tag);
    int i = 0;
    waitValid(tag);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput($sformatf("%s_nib%0d", tag, i), 32'(port_d), 32'(e));
      sendAck(2);
      i++;
    end
    checkOutput({tag, "_rv_end"}, 32'(result_valid), 32'd0);
    checkOutput({tag, "_pd_end"}, 32'(port_d), 32'd0);
    checkOutput({tag, "_leds_end"}, 32'(leds), 32'd0);
    in_send   = 1'b0;
    model_acc = 0;
    model_cnt = 0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    count_in   = 4'h0;
    mcu_strobe = 1'b0;
    mcu_done   = 1'b0;
    mcu_ack    = 1'b0;
    model_acc  = 0;
    model_cnt  = 0;
    in_send    = 1'b0;
    tick(3);
    checkOutput("rst_pd", 32'(port_d), 32'd0);
    checkOutput("rst_rv", 32'(result_valid), 32'd0);
    checkOutput("rst_leds", 32'(leds), 32'd0);
    checkOutput("rst_ovr", 32'(overrun), 32'd0);
    reset = 1'b0;
    tick(2);

    // Basic burst 3+8+0+5 = 0x0010, with a stray ack while accumulating.
    applyStimulus(4'd3, 1'b0);
    applyStimulus(4'd8, 1'b0);
    applyStimulus(4'd0, 1'b0);
    applyStimulus(4'd5, 1'b0);
    checkOutput("basic_leds", 32'(leds), 32'(model_cnt));
    sendAck(2);
    checkOutput("accum_ack_rv", 32'(result_valid), 32'd0);
    checkOutput("accum_ack_leds", 32'(leds), 32'd4);
    sendDone();
    readout("basic");

    // Strobe and done together on top of acc=9.
    applyStimulus(4'd4, 1'b0);
    applyStimulus(4'd5, 1'b0);
    applyStimulus(4'd7, 1'b1);
    readout("same_cycle");

    // Held ack advances once; done during readout is ignored.
    for (int i = 0; i < 36; i++) applyStimulus(4'd8, 1'b0);
    applyStimulus(4'd3, 1'b0);
    checkOutput("hold_leds", 32'(leds), 32'd37);
    sendDone();
    waitValid("hold");
    e = exp_q.pop_front();
    checkOutput("hold_nib0", 32'(port_d), 32'(e));
    sendAck(10);
    e = exp_q.pop_front();
    checkOutput("hold_nib1", 32'(port_d), 32'(e));
    sendDone();
    checkOutput("send_done_pd", 32'(port_d), 32'(e));
    tick(5);
    checkOutput("stable_pd", 32'(port_d), 32'(e));
    sendAck(2);
    readout("hold");

    // Strobe in SEND flags overrun without disturbing the total.
    applyStimulus(4'd5, 1'b0);
    sendDone();
    waitValid("ovr");
    applyStimulus(4'd8, 1'b0);
    checkOutput("ovr_set", 32'(overrun), 32'd1);
    readout("ovr");
    applyStimulus(4'd2, 1'b0);
    sendDone();
    readout("ovr_next");
    checkOutput("ovr_sticky", 32'(overrun), 32'd1);

    // Reset in the middle of a readout aborts it.
    applyStimulus(4'd6, 1'b0);
    sendDone();
    waitValid("abort");
    sendAck(2);
    sendAck(2);
    reset = 1'b1;
    tick(1);
    checkOutput("abort_pd", 32'(port_d), 32'd0);
    checkOutput("abort_rv", 32'(result_valid), 32'd0);
    checkOutput("abort_leds", 32'(leds), 32'd0);
    checkOutput("abort_ovr", 32'(overrun), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    in_send   = 1'b0;
    model_acc = 0;
    model_cnt = 0;
    tick(2);

    // Saturation: 8200 * 8 exceeds the 16-bit total and the 8-bit counter.
    for (int i = 0; i < 8200; i++) applyStimulus(4'd8, 1'b0);
    checkOutput("sat_leds", 32'(leds), 32'hFF);
    sendDone();
    readout("sat");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
